rsa: RTL and testbench



---
 rtl/rsa_pkg.sv | 30 +++
 rtl/rsa_seq_cnt.sv | 40 ++++
 rtl/rsa.sv | 141 ++++++++++++++
 tb/tb_rsa.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// rsa_pkg: shared definitions for the RSA control core.
//   - one-hot stage encodings, also used as bit indices on the 3-bit handshake buses
//   - FSM state enumeration
//   - tile_count(): row tiles needed for an n-landmark covariance, with clamping
package rsa_pkg;

   localparam int unsigned STAGE_W = 3;

   localparam logic [STAGE_W-1:0] STAGE_IDLE = 3'b000;
   localparam logic [STAGE_W-1:0] STAGE_PRD  = 3'b001;
   localparam logic [STAGE_W-1:0] STAGE_NEW  = 3'b010;
   localparam logic [STAGE_W-1:0] STAGE_UPD  = 3'b100;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RECV = 2'd1,
      S_COMP = 2'd2,
      S_SEND = 2'd3
   } state_e;

   // ceil((3 + 2*n_eff) / x), where n_eff = min(n, max_lm)
   function automatic int unsigned tile_count(input int unsigned n,
                                              input int unsigned x,
                                              input int unsigned max_lm);
      int unsigned n_eff;
      n_eff = (n > max_lm) ? max_lm : n;
      return (3 + 2 * n_eff + x - 1) / x;
   endfunction

endpackage

// File: rtl/rsa_seq_cnt.sv
// rsa_seq_cnt: loadable down-counter that times the COMP phase.
//   clk, sys_rst  : clock, synchronous active-low reset
//   load, load_val: load a new count (takes priority over dec)
//   dec           : decrement by one while non-zero
//   done_c        : count has reached zero
module rsa_seq_cnt #(
   parameter int unsigned W = 10
) (
   input  logic         clk,
   input  logic         sys_rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         done_c
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   // next count: load wins, decrement saturates at zero
   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (dec && (count_q != '0)) begin
         count_d = count_q - W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!sys_rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign done_c = (count_q == '0);

endmodule

// File: rtl/rsa.sv
// rsa: control core of the reconfigurable systolic array.
// Accepts one EKF stage at a time, receives nonlinear-unit inputs, times the tiled
// covariance computation, then returns results to the nonlinear unit.
//   clk, sys_rst     : clock, synchronous active-low reset
//   landmark_num     : landmark count n, sampled on stage accept
//   stage_val/rdy    : one-hot stage request handshake (bit0 PRD, bit1 NEW, bit2 UPD)
//   nonlinear_s_val  / nonlinear_m_rdy : nonlinear unit -> RSA data handshake
//   nonlinear_m_val  / nonlinear_s_rdy : RSA -> nonlinear unit result handshake
module rsa
   import rsa_pkg::*;
#(
   parameter int unsigned X            = 4,
   parameter int unsigned Y            = 4,
   parameter int unsigned L            = 4,
   parameter int unsigned RSA_DW       = 16,
   parameter int unsigned TB_AW        = 11,
   parameter int unsigned CB_AW        = 17,
   parameter int unsigned MAX_LANDMARK = 500,
   parameter int unsigned ROW_LEN      = 10
) (
   input  logic               clk,
   input  logic               sys_rst,
   input  logic [ROW_LEN-1:0] landmark_num,
   input  logic [2:0]         stage_val,
   output logic [2:0]         stage_rdy,
   input  logic [2:0]         nonlinear_s_val,
   output logic [2:0]         nonlinear_m_rdy,
   output logic [2:0]         nonlinear_m_val,
   input  logic [2:0]         nonlinear_s_rdy
);

   // longest COMP phase sets the counter width (counter holds T*L-1)
   localparam int unsigned MAX_TL = tile_count(MAX_LANDMARK, X, MAX_LANDMARK) * L;
   localparam int unsigned CNT_W  = (MAX_TL > 2) ? $clog2(MAX_TL) : 1;

   // datapath-only parameters must still describe a real array
   if (X == 0 || Y == 0 || L == 0 || RSA_DW == 0 || TB_AW == 0 || CB_AW == 0) begin : g_bad_cfg
      $error("rsa: zero-sized array or bus parameter");
   end

   state_e               state_q, state_d;
   logic [STAGE_W-1:0]   cur_stage_q, cur_stage_d;
   logic [ROW_LEN-1:0]   n_q, n_d;
   logic [2:0]           stage_rdy_q, stage_rdy_d;
   logic [2:0]           m_rdy_q, m_rdy_d;
   logic [2:0]           m_val_q, m_val_d;

   logic                 cnt_load;
   logic                 cnt_dec;
   logic [CNT_W-1:0]     cnt_load_val;
   logic                 cnt_done_c;
   logic                 stage_onehot_c;

   assign stage_onehot_c = (stage_val == STAGE_PRD) || (stage_val == STAGE_NEW) ||
                           (stage_val == STAGE_UPD);

   // counter runs T*L cycles: loaded with T*L-1, SEND taken on the zero cycle
   assign cnt_load_val = CNT_W'(tile_count(32'(n_q), X, MAX_LANDMARK) * L - 1);

   rsa_seq_cnt #(
      .W (CNT_W)
   ) u_seq_cnt (
      .clk      (clk),
      .sys_rst  (sys_rst),
      .load     (cnt_load),
      .load_val (cnt_load_val),
      .dec      (cnt_dec),
      .done_c   (cnt_done_c)
   );

   // next state plus registered Moore outputs decoded from the next state
   always_comb begin
      state_d     = state_q;
      cur_stage_d = cur_stage_q;
      n_d         = n_q;
      cnt_load    = 1'b0;
      cnt_dec     = 1'b0;
      stage_rdy_d = 3'b000;
      m_rdy_d     = 3'b000;
      m_val_d     = 3'b000;

      unique case (state_q)
         S_IDLE: begin
            if (stage_onehot_c) begin
               state_d     = S_RECV;
               cur_stage_d = stage_val;
               n_d         = landmark_num;
            end
         end
         S_RECV: begin
            if ((nonlinear_s_val & cur_stage_q) != 3'b000) begin
               state_d  = S_COMP;
               cnt_load = 1'b1;
            end
         end
         S_COMP: begin
            if (cnt_done_c) begin
               state_d = S_SEND;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         S_SEND: begin
            if ((nonlinear_s_rdy & cur_stage_q) != 3'b000) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      unique case (state_d)
         S_IDLE:  stage_rdy_d = 3'b111;
         S_RECV:  m_rdy_d     = cur_stage_d;
         S_SEND:  m_val_d     = cur_stage_d;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!sys_rst) begin
         state_q     <= S_IDLE;
         cur_stage_q <= STAGE_IDLE;
         n_q         <= '0;
         stage_rdy_q <= 3'b000;
         m_rdy_q     <= 3'b000;
         m_val_q     <= 3'b000;
      end else begin
         state_q     <= state_d;
         cur_stage_q <= cur_stage_d;
         n_q         <= n_d;
         stage_rdy_q <= stage_rdy_d;
         m_rdy_q     <= m_rdy_d;
         m_val_q     <= m_val_d;
      end
   end

   assign stage_rdy       = stage_rdy_q;
   assign nonlinear_m_rdy = m_rdy_q;
   assign nonlinear_m_val = m_val_q;

endmodule

// File: tb/tb_rsa.sv
// tb_rsa: directed self-checking bench for the RSA control core.
module tb_rsa;

   logic       clk;
   logic       sys_rst;
   logic [9:0] landmark_num;
   logic [2:0] stage_val;
   logic [2:0] stage_rdy;
   logic [2:0] nonlinear_s_val;
   logic [2:0] nonlinear_m_rdy;
   logic [2:0] nonlinear_m_val;
   logic [2:0] nonlinear_s_rdy;

   int n_cmp = 0;
   int n_err = 0;

   rsa dut (
      .clk             (clk),
      .sys_rst         (sys_rst),
      .landmark_num    (landmark_num),
      .stage_val       (stage_val),
      .stage_rdy       (stage_rdy),
      .nonlinear_s_val (nonlinear_s_val),
      .nonlinear_m_rdy (nonlinear_m_rdy),
      .nonlinear_m_val (nonlinear_m_val),
      .nonlinear_s_rdy (nonlinear_s_rdy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // one rising edge, then settle to the falling edge for sampling/driving
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // after the s_val transfer edge: m_val must stay low for tl-1 edges, rise on edge tl
   task automatic comp_wait(input string tag, input int tl, input logic [2:0] stg);
      repeat (tl - 1) tick();
      check({tag, "_comp_hold"}, nonlinear_m_val, 3'b000);
      tick();
      check({tag, "_comp_done"}, nonlinear_m_val, stg);
   endtask

   // complete stage with correct handshakes and a known COMP length
   task automatic run_stage(input string tag, input logic [9:0] n, input logic [2:0] stg,
                            input int tl);
      landmark_num = n;
      stage_val    = stg;
      tick();
      check({tag, "_accept_mrdy"}, nonlinear_m_rdy, stg);
      check({tag, "_accept_srdy"}, stage_rdy, 3'b000);
      stage_val       = 3'b000;
      nonlinear_s_val = stg;
      tick();
      check({tag, "_recv_done"}, nonlinear_m_rdy, 3'b000);
      nonlinear_s_val = 3'b000;
      comp_wait(tag, tl, stg);
      nonlinear_s_rdy = stg;
      tick();
      nonlinear_s_rdy = 3'b000;
      check({tag, "_idle_srdy"}, stage_rdy, 3'b111);
      check({tag, "_idle_mval"}, nonlinear_m_val, 3'b000);
   endtask

   initial begin
      sys_rst         = 1'b0;
      landmark_num    = 10'd0;
      stage_val       = 3'b000;
      nonlinear_s_val = 3'b000;
      nonlinear_s_rdy = 3'b000;

      // reset held for five edges
      @(negedge clk);
      repeat (5) tick();
      check("rst_srdy", stage_rdy, 3'b000);
      check("rst_mrdy", nonlinear_m_rdy, 3'b000);
      check("rst_mval", nonlinear_m_val, 3'b000);
      sys_rst = 1'b1;
      tick();
      check("post_rst_srdy", stage_rdy, 3'b111);

      // PRD, n=5: T=ceil(13/4)=4, COMP 16 cycles; UPD request during COMP is ignored
      landmark_num = 10'd5;
      stage_val    = 3'b001;
      tick();
      check("prd_mrdy", nonlinear_m_rdy, 3'b001);
      check("prd_srdy", stage_rdy, 3'b000);
      stage_val       = 3'b000;
      nonlinear_s_val = 3'b001;
      tick();
      nonlinear_s_val = 3'b000;
      stage_val       = 3'b100;
      check("prd_busy_srdy", stage_rdy, 3'b000);
      comp_wait("prd", 16, 3'b001);
      stage_val       = 3'b000;
      nonlinear_s_rdy = 3'b001;
      tick();
      nonlinear_s_rdy = 3'b000;
      check("prd_ret_srdy", stage_rdy, 3'b111);
      check("prd_ret_mval", nonlinear_m_val, 3'b000);

      // multi-hot request must not be accepted
      stage_val = 3'b011;
      tick();
      check("multi_srdy", stage_rdy, 3'b111);
      check("multi_mrdy", nonlinear_m_rdy, 3'b000);
      tick();
      check("multi_mrdy2", nonlinear_m_rdy, 3'b000);
      stage_val = 3'b000;

      // NEW stage with wrong-bit handshakes first
      landmark_num = 10'd5;
      stage_val    = 3'b010;
      tick();
      check("new_mrdy", nonlinear_m_rdy, 3'b010);
      stage_val       = 3'b000;
      nonlinear_s_val = 3'b001;
      tick();
      check("new_wrong_sval", nonlinear_m_rdy, 3'b010);
      nonlinear_s_val = 3'b010;
      tick();
      check("new_sval_xfer", nonlinear_m_rdy, 3'b000);
      nonlinear_s_val = 3'b000;
      comp_wait("new", 16, 3'b010);
      nonlinear_s_rdy = 3'b100;
      tick();
      check("new_wrong_srdy", nonlinear_m_val, 3'b010);
      check("new_wrong_srdy_st", stage_rdy, 3'b000);
      nonlinear_s_rdy = 3'b010;
      tick();
      nonlinear_s_rdy = 3'b000;
      check("new_ret_srdy", stage_rdy, 3'b111);

      // boundary tile counts
      run_stage("n0", 10'd0, 3'b100, 4);       // ceil(3/4)=1
      run_stage("n7", 10'd7, 3'b010, 20);      // ceil(17/4)=5
      run_stage("n600", 10'd600, 3'b001, 1004); // clamped: ceil(1003/4)=251

      // reset in the middle of an UPD COMP phase
      landmark_num = 10'd5;
      stage_val    = 3'b100;
      tick();
      check("upd_mrdy", nonlinear_m_rdy, 3'b100);
      stage_val       = 3'b000;
      nonlinear_s_val = 3'b100;
      tick();
      nonlinear_s_val = 3'b000;
      repeat (5) tick();
      sys_rst = 1'b0;
      tick();
      check("midrst_mval", nonlinear_m_val, 3'b000);
      check("midrst_mrdy", nonlinear_m_rdy, 3'b000);
      check("midrst_srdy", stage_rdy, 3'b000);
      sys_rst = 1'b1;
      tick();
      check("midrst_rel_srdy", stage_rdy, 3'b111);

      // fresh stage after reset uses a cleanly reloaded counter
      run_stage("post_rst", 10'd1, 3'b001, 8);  // ceil(5/4)=2

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // hard ceiling on simulated time
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, observed running expected done");
      $fatal(1, "timeout");
   end

endmodule
